stack_seq: RTL

Stack access sequencer sitting directly upstream of the stack pointer register. Accepts PUSH/POP/PEEK requests from the control unit, performs the single-word memory transaction at the address derived from the current SP value, then issues the one-cycle increment/decrement pulse that the SP register consumes. Detects overflow/underflow against parameterised bounds and refuses the operation without touching memory or SP.

---
 rtl/stack_seq.sv | 64 ++++++
 1 files changed

// File: rtl/stack_seq.sv
// stack_seq: sequences PUSH/POP/PEEK memory accesses and issues SP increment/decrement pulses
module stack_seq #(
    parameter logic [15:0] STACK_EMPTY = 16'hFFFF,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sp_val,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, MEM, UPD, ERR} state_t;
    state_t state, state_nx;
    logic [1:0] kind;
    logic accept, bad;
    // next state, bound check and state-decoded outputs; kind 2'b1x behaves as PEEK
    always_comb begin
        accept = op_valid && state == IDLE;
        bad = op == 2'b00 ? sp_val < STACK_LIMIT : sp_val == STACK_EMPTY;
        op_ready = state == IDLE;
        mem_req = state == MEM;
        err = state == ERR;
        sp_dec = state == UPD && kind == 2'b00;
        sp_inc = state == UPD && kind == 2'b01;
        rdata_valid = state == UPD && kind != 2'b00;
        state_nx = state == IDLE ? (op_valid ? (bad ? ERR : MEM) : IDLE) :
                   state == MEM  ? (mem_ack ? UPD : MEM) : IDLE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // request capture at accept and read data capture on the read ack (read data shares the wdata port)
    always_ff @(posedge clk) begin
        if (rst) begin
            kind <= 2'b00;
            mem_we <= 1'b0;
            mem_addr <= 16'h0;
            mem_wdata <= 16'h0;
            rdata <= 16'h0;
        end else begin
            if (accept && !bad) begin
                kind <= op;
                mem_we <= op == 2'b00;
                mem_addr <= op == 2'b00 ? sp_val : sp_val + 16'd1;
                if (op == 2'b00) mem_wdata <= wdata;
            end
            if (state == MEM && mem_ack && !mem_we) rdata <= wdata;
        end
    end
endmodule
